// File: rtl/debounce_multi.sv
// ============================================================================
// Module      : debounce_multi
// Description : Multi-channel synchroniser/debouncer with per-channel edge
//               strobes and saturating event counters with sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EVT_WIDTH   = 16,
    parameter int INIT_LEVEL  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           sig,
    input  logic [CNT_WIDTH-1:0]          dbnc_len,
    input  logic [1:0]                    edge_mode,
    input  logic [CHANNELS-1:0]           clear,
    output logic [CHANNELS-1:0]           level,
    output logic [CHANNELS-1:0]           pulse,
    output logic [CHANNELS*EVT_WIDTH-1:0] evt_cnt,
    output logic [CHANNELS-1:0]           ovf
);

    localparam logic                 c_init    = (INIT_LEVEL != 0);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EVT_WIDTH-1:0] c_evt_one = {{(EVT_WIDTH-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_WIDTH-1:0]   r_cnt;
        logic                   r_level;
        logic                   r_pulse;
        logic [EVT_WIDTH-1:0]   r_evt;
        logic                   r_ovf;
        logic                   w_synced;
        logic                   w_pending;
        logic                   w_flip;
        logic                   w_event;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= {SYNC_STAGES{c_init}};
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], sig[i]};
            end
        end

        assign w_synced  = r_sync[SYNC_STAGES-1];
        assign w_pending = (w_synced != r_level);
        // >= so that lowering dbnc_len mid-count accepts on the next edge
        assign w_flip    = w_pending && (r_cnt >= dbnc_len);
        assign w_event   = w_flip && (r_level ? edge_mode[0] : edge_mode[1]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt   <= '0;
                r_level <= c_init;
            end else begin
                if (!w_pending || w_flip) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
                if (w_flip) begin
                    r_level <= ~r_level;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pulse <= 1'b0;
                r_evt   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_pulse <= w_event;
                if (clear[i]) begin
                    // a coincident event survives the clear
                    r_evt <= w_event ? c_evt_one : '0;
                    r_ovf <= 1'b0;
                end else if (w_event) begin
                    if (&r_evt) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_evt <= r_evt + c_evt_one;
                    end
                end
            end
        end

        assign level[i]                         = r_level;
        assign pulse[i]                         = r_pulse;
        assign ovf[i]                           = r_ovf;
        assign evt_cnt[i*EVT_WIDTH +: EVT_WIDTH] = r_evt;
    end

endmodule

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// ============================================================================
// Module      : tb_debounce_multi
// Description : Scoreboard bench for debounce_multi (4 channels, 4-bit counts).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_multi;

    localparam int C_CH  = 4;
    localparam int C_EW  = 4;
    localparam int C_SS  = 2;

    typedef struct {
        int             ch;
        int             cyc;
        logic [C_EW-1:0] evt;
        logic           ovf;
        logic           lvl;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [C_CH-1:0]        sig;
    logic [7:0]             dbnc_len;
    logic [1:0]             edge_mode;
    logic [C_CH-1:0]        clear;
    logic [C_CH-1:0]        level;
    logic [C_CH-1:0]        pulse;
    logic [C_CH*C_EW-1:0]   evt_cnt;
    logic [C_CH-1:0]        ovf;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   m_evt[C_CH];
    bit   m_ovf[C_CH];

    debounce_multi #(
        .CHANNELS   (C_CH),
        .CNT_WIDTH  (8),
        .SYNC_STAGES(C_SS),
        .EVT_WIDTH  (C_EW),
        .INIT_LEVEL (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig      (sig),
        .dbnc_len (dbnc_len),
        .edge_mode(edge_mode),
        .clear    (clear),
        .level    (level),
        .pulse    (pulse),
        .evt_cnt  (evt_cnt),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every observed strobe must match the oldest expected one exactly.
    always @(negedge clk) begin
        for (int ch = 0; ch < C_CH; ch++) begin
            if (pulse[ch] === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse ch=%0d cyc=%0d got pulse=1 expected 0", ch, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.ch !== ch || mon_e.cyc !== cyc ||
                        evt_cnt[ch*C_EW +: C_EW] !== mon_e.evt ||
                        ovf[ch] !== mon_e.ovf || level[ch] !== mon_e.lvl) begin
                        failures++;
                        $display("FAIL pulse_match got ch=%0d cyc=%0d evt=%0d ovf=%0b lvl=%0b expected ch=%0d cyc=%0d evt=%0d ovf=%0b lvl=%0b",
                                 ch, cyc, evt_cnt[ch*C_EW +: C_EW], ovf[ch], level[ch],
                                 mon_e.ch, mon_e.cyc, mon_e.evt, mon_e.ovf, mon_e.lvl);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int ch, input int at, input logic lvl);
        exp_t e;
        if (m_evt[ch] == (1 << C_EW) - 1) m_ovf[ch] = 1'b1;
        else m_evt[ch]++;
        e.ch = ch; e.cyc = at; e.evt = C_EW'(m_evt[ch]); e.ovf = m_ovf[ch]; e.lvl = lvl;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b1; sig = '1; clear = '0; dbnc_len = 8'd255; edge_mode = 2'b01;
        step(3);
        rst = 1'b0;
        step(1);
        checks++;
        if (level !== 4'hF || pulse !== 4'h0 || evt_cnt !== '0 || ovf !== 4'h0) begin
            failures++;
            $display("FAIL reset_state got level=%h pulse=%h evt=%h ovf=%h expected F 0 0 0", level, pulse, evt_cnt, ovf);
        end
        step(1000);
        checks++;
        if (level !== 4'hF || evt_cnt !== '0) begin
            failures++;
            $display("FAIL idle_hold got level=%h evt=%h expected F 0", level, evt_cnt);
        end
    endtask

    task automatic test_falling;
        int c;
        c = cyc; sig[0] = 1'b0;
        expect_pulse(0, c + C_SS + 255 + 1, 1'b0);
        step(257);
        checks++;
        if (level[0] !== 1'b1) begin
            failures++; $display("FAIL fall_early got level0=%b expected 1", level[0]);
        end
        step(1);
        checks++;
        if (level[0] !== 1'b0) begin
            failures++; $display("FAIL fall_latency got level0=%b expected 0", level[0]);
        end
        step(20);
        checks++;
        if (evt_cnt[3:0] !== 4'd1 || sb.size() != 0) begin
            failures++; $display("FAIL fall_count got evt0=%0d pending=%0d expected 1 0", evt_cnt[3:0], sb.size());
        end
        c = cyc; sig[0] = 1'b1;
        step(257);
        checks++;
        if (level[0] !== 1'b0) begin
            failures++; $display("FAIL rise_early got level0=%b expected 0", level[0]);
        end
        step(1);
        checks++;
        if (level[0] !== 1'b1 || evt_cnt[3:0] !== 4'd1) begin
            failures++; $display("FAIL rise_nopulse got level0=%b evt0=%0d expected 1 1", level[0], evt_cnt[3:0]);
        end
    endtask

    task automatic test_glitch;
        int c;
        sig[1] = 1'b0; step(255); sig[1] = 1'b1; step(300);
        checks++;
        if (level[1] !== 1'b1 || evt_cnt[7:4] !== 4'd0) begin
            failures++; $display("FAIL short_glitch got level1=%b evt1=%0d expected 1 0", level[1], evt_cnt[7:4]);
        end
        c = cyc; sig[1] = 1'b0;
        expect_pulse(1, c + 258, 1'b0);
        step(256); sig[1] = 1'b1;
        step(10);
        checks++;
        if (level[1] !== 1'b0) begin
            failures++; $display("FAIL long_glitch got level1=%b expected 0", level[1]);
        end
        step(260);
        checks++;
        if (level[1] !== 1'b1 || sb.size() != 0) begin
            failures++; $display("FAIL glitch_recover got level1=%b pending=%0d expected 1 0", level[1], sb.size());
        end
    endtask

    task automatic test_modes;
        int c;
        edge_mode = 2'b11;
        for (int t = 0; t < 5; t++) begin
            c = cyc; sig[2] = ~sig[2];
            expect_pulse(2, c + 258, sig[2]);
            step(300);
        end
        checks++;
        if (evt_cnt[11:8] !== 4'd5 || sb.size() != 0) begin
            failures++; $display("FAIL both_edges got evt2=%0d pending=%0d expected 5 0", evt_cnt[11:8], sb.size());
        end
        clear[2] = 1'b1; step(1); clear[2] = 1'b0;
        m_evt[2] = 0; m_ovf[2] = 1'b0;
        checks++;
        if (evt_cnt[11:8] !== 4'd0) begin
            failures++; $display("FAIL clear2 got evt2=%0d expected 0", evt_cnt[11:8]);
        end
        edge_mode = 2'b00; sig[2] = 1'b1; step(300);
        checks++;
        if (level[2] !== 1'b1 || evt_cnt[11:8] !== 4'd0) begin
            failures++; $display("FAIL mode_none got level2=%b evt2=%0d expected 1 0", level[2], evt_cnt[11:8]);
        end
        edge_mode = 2'b10;
        for (int t = 0; t < 5; t++) begin
            c = cyc; sig[2] = ~sig[2];
            if (sig[2] == 1'b1) expect_pulse(2, c + 258, 1'b1);
            step(300);
        end
        checks++;
        if (evt_cnt[11:8] !== 4'd2 || sb.size() != 0) begin
            failures++; $display("FAIL rise_only got evt2=%0d pending=%0d expected 2 0", evt_cnt[11:8], sb.size());
        end
        edge_mode = 2'b00; sig[2] = 1'b1; step(300);
    endtask

    task automatic test_saturation;
        int   c;
        exp_t e;
        dbnc_len = 8'd3; edge_mode = 2'b01;
        for (int n = 0; n < 17; n++) begin
            c = cyc; sig[3] = 1'b0;
            expect_pulse(3, c + C_SS + 3 + 1, 1'b0);
            step(10); sig[3] = 1'b1; step(10);
        end
        checks++;
        if (evt_cnt[15:12] !== 4'd15 || ovf[3] !== 1'b1 || sb.size() != 0) begin
            failures++; $display("FAIL saturate got evt3=%0d ovf3=%b pending=%0d expected 15 1 0", evt_cnt[15:12], ovf[3], sb.size());
        end
        c = cyc; sig[3] = 1'b0;
        step(5);
        clear[3] = 1'b1;
        m_evt[3] = 1; m_ovf[3] = 1'b0;
        e.ch = 3; e.cyc = c + 6; e.evt = 4'd1; e.ovf = 1'b0; e.lvl = 1'b0;
        sb.push_back(e);
        step(1); clear[3] = 1'b0;
        checks++;
        if (evt_cnt[15:12] !== 4'd1 || ovf[3] !== 1'b0) begin
            failures++; $display("FAIL clear_coincident got evt3=%0d ovf3=%b expected 1 0", evt_cnt[15:12], ovf[3]);
        end
        sig[3] = 1'b1; step(10);
        checks++;
        if (sb.size() != 0 || level[3] !== 1'b1) begin
            failures++; $display("FAIL sat_tail got pending=%0d level3=%b expected 0 1", sb.size(), level[3]);
        end
    endtask

    task automatic test_reset_midcount;
        int c;
        dbnc_len = 8'd255; edge_mode = 2'b01;
        sig[0] = 1'b0;
        step(102);
        #2 rst = 1'b1;
        #1;
        for (int ch = 0; ch < C_CH; ch++) begin
            m_evt[ch] = 0; m_ovf[ch] = 1'b0;
        end
        checks++;
        if (level !== 4'hF || evt_cnt !== '0 || ovf !== 4'h0 || pulse !== 4'h0) begin
            failures++; $display("FAIL async_reset got level=%h evt=%h ovf=%h pulse=%h expected F 0 0 0", level, evt_cnt, ovf, pulse);
        end
        step(3);
        c = cyc; rst = 1'b0;
        expect_pulse(0, c + C_SS + 255 + 1, 1'b0);
        step(257);
        checks++;
        if (level[0] !== 1'b1) begin
            failures++; $display("FAIL post_reset_early got level0=%b expected 1", level[0]);
        end
        step(1);
        checks++;
        if (level[0] !== 1'b0) begin
            failures++; $display("FAIL post_reset_latency got level0=%b expected 0", level[0]);
        end
        step(5);
        checks++;
        if (sb.size() != 0 || evt_cnt[3:0] !== 4'd1) begin
            failures++; $display("FAIL post_reset_pulse got pending=%0d evt0=%0d expected 0 1", sb.size(), evt_cnt[3:0]);
        end
    endtask

    initial begin
        rst = 1'b1; sig = '1; clear = '0; dbnc_len = 8'd255; edge_mode = 2'b01;
        for (int ch = 0; ch < C_CH; ch++) begin
            m_evt[ch] = 0; m_ovf[ch] = 1'b0;
        end
        test_reset;
        test_falling;
        test_glitch;
        test_modes;
        test_saturation;
        test_reset_midcount;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel input synchroniser and debouncer with per-channel edge-event counting. Each channel synchronises an asynchronous input, requires a run-time-programmable stable interval before accepting a level change, and emits a one-cycle strobe on the selected edge(s). Saturating per-channel event counters with sticky overflow let the host poll pulse totals instead of catching individual strobes. It replaces the single-channel falling-edge debouncer on the servo board's pulse-meter inputs.

## Interface
- CHANNELS, 4, number of independent input channels (1..32)
- CNT_WIDTH, 8, width of the debounce counter and of dbnc_len
- SYNC_STAGES, 2, synchroniser flop depth (>=2)
- EVT_WIDTH, 16, width of each event counter
- INIT_LEVEL, 1, reset value of synchronisers and debounced level (1 = inputs idle high, active low)

- clk  in  1  system clock (1.8432 MHz on servo board)
- rst  in  1  asynchronous, active-high reset
- sig  in  CHANNELS  asynchronous raw inputs
- dbnc_len  in  CNT_WIDTH  debounce threshold L, shared by all channels, quasi-static
- edge_mode  in  2  00 none, 01 falling, 10 rising, 11 both
- clear  in  CHANNELS  synchronous per-channel clear of evt_cnt and ovf
- level  out  CHANNELS  debounced level
- pulse  out  CHANNELS  one-cycle strobe per accepted edge matching edge_mode
- evt_cnt  out  CHANNELS*EVT_WIDTH  saturating event counts, channel i at bits [i*EVT_WIDTH +: EVT_WIDTH]
- ovf  out  CHANNELS  sticky: counter was at saturation when another event arrived

## Operation
- Reset (async): sync chain and level = INIT_LEVEL for every channel; debounce cnt, pulse, evt_cnt, ovf = 0. Because sync resets to INIT_LEVEL, an input held at INIT_LEVEL produces no pulse after reset.
- Per channel, two states: IDLE (sync output == level) and PENDING (mismatch).
- IDLE: cnt held at 0.
- PENDING: cnt increments each cycle. When cnt >= dbnc_len at a clock edge, level toggles and cnt returns to 0.
- A mismatch lasting fewer cycles than required returns the channel to IDLE with cnt = 0. There is no partial credit.
- Comparison is >=, so lowering dbnc_len mid-count causes the flip on the next edge. cnt never wraps.
- Accepted edge: level toggle where old level 1 means falling, old level 0 means rising. pulse[i] is registered and is high for exactly the cycle in which level[i] first shows the new value, if edge_mode enables that edge. edge_mode 00 suppresses pulses; level still tracks.
- evt_cnt[i] increments on each pulse[i]. At all-ones it holds and sets ovf[i].
- clear[i] zeroes evt_cnt[i] and ovf[i]. If clear[i] coincides with pulse[i], the result is evt_cnt = 1, ovf = 0 (the event is not lost).
- Channels are fully independent; simultaneous events on all channels are all counted.

## Timing
- sig change sampled at edge k reaches the last sync stage at edge k+SYNC_STAGES-1.
- level changes at edge k+SYNC_STAGES+L, where L = dbnc_len. Total latency is SYNC_STAGES+L+1 edges including k.
- Defaults (L=255): 258 edges, ≈140 µs. L=0 gives the minimum, SYNC_STAGES+1 edges.
- pulse, level, and evt_cnt increment all update on the same edge. evt_cnt shows the new value when pulse is high.
- Maximum accepted toggle rate is one per L+1 cycles per channel.
- Changes to edge_mode and dbnc_len act on the next edge. There is no internal shadowing.

## Test plan
- Reset with sig = all 1s, then hold 1000 cycles -> level = 1111, pulse never asserts, evt_cnt all 0.
- Channel 0 low-going step, L=255, mode 01 -> level[0] falls and pulse[0] is high for one cycle exactly 258 edges after first sampling edge; evt_cnt0 = 1. Return high -> no pulse, level[0] = 1 after 258 edges.
- Glitch of L cycles (255) low on channel 1, L=255 -> no level change, cnt back to 0. Glitch of 256 cycles -> level changes.
- Mode 11, channel 2 toggles 5 times with 300-cycle spacing, L=255 -> 5 pulses, evt_cnt2 = 5. Mode 10, same stimulus -> pulses on rising edges only.
- EVT_WIDTH=4, 17 falling events on channel 3 -> evt_cnt3 = 15, ovf3 = 1. clear[3] coincident with an 18th pulse -> evt_cnt3 = 1, ovf3 = 0.
- rst asserted mid-count (cnt = 100) with sig low -> level = 1, cnt = 0 immediately (async). After release with sig still low -> pulse after SYNC_STAGES+L+1 edges.
